// File: rtl/randomizer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : randomizer_pkg                                        |
// | Purpose  : Shared PHY constants and types for the 802.16 style   |
// |            bit-serial randomizer (15-bit LFSR, 1 + x^14 + x^15). |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package randomizer_pkg;

  localparam int LFSR_LEN = 15;

  // 802.16 default burst seed, seed[14] = stage 1 ... seed[0] = stage 15
  localparam logic [LFSR_LEN-1:0] DEFAULT_SEED = 15'b011_0111_0001_0101;

  // What the register does on the coming clock edge, in priority order
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_RESET   = 2'd1,
    ACT_LOAD    = 2'd2,
    ACT_ADVANCE = 2'd3
  } lfsr_action_e;

  // Stages 14 and 15 sit in the two least significant bits of the state
  function automatic logic prbs_tap(input logic [LFSR_LEN-1:0] state);
    return state[1] ^ state[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/randomizer_prbs15_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : randomizer_prbs15_lfsr                                |
// | Purpose  : PRBS15 generator (1 + x^14 + x^15) with seed bypass:  |
// |            until the first advance after reset/load the seed     |
// |            port itself is the effective state, so the very first |
// |            bit of a burst needs no clock edge.                   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module randomizer_prbs15_lfsr
  import randomizer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] seed,
  output logic                prbs
);

  logic [LFSR_LEN-1:0] r_state;
  logic                r_primed;
  logic [LFSR_LEN-1:0] w_state;
  lfsr_action_e        w_action;

  // Effective state: the seed stands in for the register until primed
  always_comb begin
    w_state = r_primed ? r_state : seed;
    prbs    = prbs_tap(w_state);
  end

  // Decode the edge action with reset > load > enable priority
  always_comb begin
    w_action = ACT_HOLD;
    if (reset) begin
      w_action = ACT_RESET;
    end else if (load) begin
      w_action = ACT_LOAD;
    end else if (enable) begin
      w_action = ACT_ADVANCE;
    end
  end

  // Register update; load only disarms, the seed is re-read on the next advance
  always_ff @(posedge clock) begin
    case (w_action)
      ACT_RESET: begin
        r_state  <= '0;
        r_primed <= 1'b0;
      end
      ACT_LOAD: begin
        r_primed <= 1'b0;
      end
      ACT_ADVANCE: begin
        r_state  <= {prbs, w_state[LFSR_LEN-1:1]};
        r_primed <= 1'b1;
      end
      default: begin
        r_state  <= r_state;
        r_primed <= r_primed;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/randomizer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : randomizer                                            |
// | Purpose  : Bit-serial 802.16 style data randomizer. Each input   |
// |            bit is XORed with the PRBS15 bit when enabled, else   |
// |            passed through. Zero latency: o is combinational.     |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module randomizer
  import randomizer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                Enable,
  input  logic                load,
  input  logic [LFSR_LEN-1:0] seed,
  input  logic                pi,
  output logic                o
);

  logic w_prbs;

  randomizer_prbs15_lfsr u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (Enable),
    .load   (load),
    .seed   (seed),
    .prbs   (w_prbs)
  );

  // Scramble while enabled, otherwise bypass the data untouched
  always_comb begin
    o = Enable ? (pi ^ w_prbs) : pi;
  end

endmodule
`default_nettype wire

// File: tb/tb_randomizer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_randomizer                                         |
// | Purpose  : Self-checking bench for the randomizer: standard      |
// |            vector table, burst corner sequences and a randomized |
// |            run against a stage-list PRBS reference model.        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_randomizer;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        Enable = 1'b0;
  logic        load   = 1'b0;
  logic [14:0] seed   = 15'h3715;
  logic        pi     = 1'b0;
  logic        o;

  randomizer dut (
    .clock  (clock),
    .reset  (reset),
    .Enable (Enable),
    .load   (load),
    .seed   (seed),
    .pi     (pi),
    .o      (o)
  );

  always #5 clock = ~clock;

  localparam logic [95:0] VEC_IN  = 96'hACBCD2114DAE1577C6DBF4C9;
  localparam logic [95:0] VEC_OUT = 96'h558AC4A53A1724E163AC2BF9;

  int          checks   = 0;
  int          failures = 0;
  logic [95:0] got;

  typedef struct {
    string       name;
    logic [14:0] seed;
    logic [95:0] data;
    logic [95:0] expect_o;
    int          nbits;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample o mid-cycle, then move to just after the next rising edge
  task automatic tick(output logic sampled);
    @(negedge clock);
    sampled = o;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    logic b;
    reset  = 1'b1;
    load   = 1'b0;
    Enable = 1'b0;
    tick(b);
    reset  = 1'b0;
  endtask

  // Stream data bits [first .. first+count-1] (MSB first), collecting o into got
  task automatic stream(input logic [95:0] data, input int first, input int count);
    logic b;
    for (int i = first; i < first + count; i++) begin
      pi     = data[95-i];
      Enable = 1'b1;
      tick(b);
      got[95-i] = b;
    end
  endtask

  // Reference model: list of stages 1..15, stage 1 at index 0
  bit mq[$];
  bit m_primed;

  initial begin
    logic b;
    logic exp_o;
    bit   exp_prbs;

    vecs[0] = '{"std_vector",  15'h3715, VEC_IN, VEC_OUT, 96};
    vecs[1] = '{"zero_data",   15'h3715, 96'h0, {32'hF93616B4, 64'h0}, 32};
    vecs[2] = '{"ones_data",   15'h3715, {32'hFFFFFFFF, 64'h0}, {32'h06C9E94B, 64'h0}, 32};
    vecs[3] = '{"zero_seed",   15'h0000, {32'hDEADBEEF, 64'h0}, {32'hDEADBEEF, 64'h0}, 32};

    // Table-driven bursts
    for (int v = 0; v < 4; v++) begin
      seed = vecs[v].seed;
      do_reset();
      got = '0;
      stream(vecs[v].data, 0, vecs[v].nbits);
      check(vecs[v].name, got, vecs[v].expect_o);
    end

    // First and second bit straight after reset, pi = 1
    seed = 15'h3715;
    do_reset();
    pi = 1'b1; Enable = 1'b1;
    tick(b);
    check("first_bit", {95'b0, b}, 96'd0);
    pi = 1'b1;
    tick(b);
    check("second_bit", {95'b0, b}, 96'd0);

    // Mid-burst reload restarts the sequence from the seed
    do_reset();
    got = '0;
    stream(VEC_IN, 0, 40);
    check("reload_pre40", {56'b0, got[95:56]}, {56'b0, VEC_OUT[95:56]});
    load = 1'b1; Enable = 1'b0;
    tick(b);
    load = 1'b0;
    got = '0;
    stream(VEC_IN, 0, 96);
    check("reload_restream", got, VEC_OUT);

    // Enable gap: bypass during the gap, seamless continuation after
    do_reset();
    got = '0;
    stream(VEC_IN, 0, 30);
    for (int g = 0; g < 5; g++) begin
      Enable = 1'b0;
      pi = 1'($urandom);
      tick(b);
      check("gap_bypass", {95'b0, b}, {95'b0, pi});
    end
    stream(VEC_IN, 30, 66);
    check("gap_concat", got, VEC_OUT);

    // Seed changes after the first advance are ignored
    do_reset();
    got = '0;
    stream(VEC_IN, 0, 1);
    seed = 15'h5A5A;
    stream(VEC_IN, 1, 95);
    check("seed_ignored", got, VEC_OUT);
    seed = 15'h3715;

    // reset + load + Enable together: reset wins, then seed restarts the burst
    do_reset();
    got = '0;
    stream(VEC_IN, 0, 20);
    reset = 1'b1; load = 1'b1; Enable = 1'b1; pi = 1'b0;
    tick(b);
    reset = 1'b0; load = 1'b0;
    check("prio_reg_zero", {81'b0, dut.u_lfsr.r_state}, 96'd0);
    got = '0;
    stream(VEC_IN, 0, 96);
    check("prio_restream", got, VEC_OUT);

    // Randomized run against the reference model
    do_reset();
    m_primed = 1'b0;
    mq.delete();
    for (int k = 0; k < 15; k++) mq.push_back(1'b0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset  = ($urandom_range(0, 99) < 3);
      load   = ($urandom_range(0, 99) < 5);
      Enable = ($urandom_range(0, 99) < 75);
      pi     = 1'($urandom);
      if ($urandom_range(0, 99) < 4) seed = 15'($urandom);
      if (!m_primed) begin
        mq.delete();
        for (int k = 0; k < 15; k++) mq.push_back(seed[14-k]);
      end
      exp_prbs = mq[13] ^ mq[14];
      exp_o    = Enable ? (pi ^ exp_prbs) : pi;
      tick(b);
      check("random_o", {95'b0, b}, {95'b0, exp_o});
      if (reset) begin
        for (int k = 0; k < 15; k++) mq[k] = 1'b0;
        m_primed = 1'b0;
      end else if (load) begin
        m_primed = 1'b0;
      end else if (Enable) begin
        mq.push_front(exp_prbs);
        void'(mq.pop_back());
        m_primed = 1'b1;
      end
    end
    reset = 1'b0; load = 1'b0; Enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
